// File: rtl/jp_lift_pkg.sv
// Shared definitions for the 5/3 lifting engines: state encoding, lifting
// constants and the symmetric-extension index helper.
package jp_lift_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        UPD   = 2'd1,
        PRED  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    typedef enum logic {
        ALU_UPD  = 1'b0,
        ALU_PRED = 1'b1
    } alu_mode_e;

    localparam int UPD_RND = 2;
    localparam int UPD_SH  = 2;
    localparam int PRED_SH = 1;

    // Reflects an out-of-range neighbour index back into 0..n-1 without
    // repeating the edge sample (whole-sample symmetric extension).
    function automatic int mirror_idx(input int i, input int n);
        if (i < 0)
            return -i;
        else if (i > n - 1)
            return 2 * (n - 1) - i;
        else
            return i;
    endfunction

endpackage

// File: rtl/jp_inv_lift53_if.sv
// Streaming input/output handshake bundle of the inverse lifting engine.
interface jp_inv_lift53_if #(
    parameter int W = 16
);
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] in_data_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] out_data_o;
    logic         out_last_o;
    logic         busy_o;

    modport master (
        output in_valid_i, in_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, out_last_o, busy_o
    );

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, out_last_o, busy_o
    );
endinterface

// File: rtl/jp_lift_alu.sv
// Combinational 5/3 lifting step: inverse update (subtract rounded quarter sum)
// or inverse predict (add halved sum), computed at W+2 bits and wrapped to W.
module jp_lift_alu
    import jp_lift_pkg::*;
#(
    parameter int W = 16
) (
    input  logic signed [W-1:0] sam,
    input  logic signed [W-1:0] left,
    input  logic signed [W-1:0] right,
    input  alu_mode_e           mode,
    output logic signed [W-1:0] res
);

    localparam logic signed [W+1:0] RND = (W+2)'(UPD_RND);

    logic signed [W+1:0] sum;
    logic signed [W+1:0] term;
    logic signed [W+1:0] full;

    // Arithmetic shifts floor toward minus infinity, matching the forward engine.
    always_comb begin
        sum  = (W+2)'(left) + (W+2)'(right);
        term = '0;
        full = '0;
        if (mode == ALU_UPD) begin
            term = (sum + RND) >>> UPD_SH;
            full = (W+2)'(sam) - term;
        end else begin
            term = sum >>> PRED_SH;
            full = (W+2)'(sam) + term;
        end
        res = full[W-1:0];
    end

endmodule

// File: rtl/jp_inv_lift53.sv
// Row-level inverse 5/3 lifting engine: load a row of interleaved s/d
// coefficients, run inverse update then inverse predict in place, stream out.
module jp_inv_lift53
    import jp_lift_pkg::*;
#(
    parameter int W  = 16,
    parameter int N  = 64,
    parameter int AW = 6
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    jp_inv_lift53_if.slave  bus
);

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic [W-1:0]    out_data_q, out_data_d;

    logic signed [W-1:0] row_buf [N];
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic signed [W-1:0] wr_data;

    logic [AW-1:0]       left_idx, right_idx;
    logic signed [W-1:0] alu_res;
    alu_mode_e           alu_mode;

    assign left_idx  = AW'(mirror_idx(int'(idx_q) - 1, N));
    assign right_idx = AW'(mirror_idx(int'(idx_q) + 1, N));
    assign alu_mode  = (state_q == UPD) ? ALU_UPD : ALU_PRED;

    jp_lift_alu #(.W(W)) u_alu (
        .sam   (row_buf[idx_q]),
        .left  (row_buf[left_idx]),
        .right (row_buf[right_idx]),
        .mode  (alu_mode),
        .res   (alu_res)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    // Row storage is never reset; a discarded partial row is simply overwritten.
    always_ff @(posedge clk_i) begin
        if (wr_en)
            row_buf[wr_addr] <= wr_data;
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        wr_en       = 1'b0;
        wr_addr     = idx_q;
        wr_data     = alu_res;

        case (state_q)
            LOAD: begin
                if (bus.in_valid_i && in_ready_q) begin
                    wr_en   = 1'b1;
                    wr_data = $signed(bus.in_data_i);
                    if (idx_q == AW'(N - 1)) begin
                        state_d    = UPD;
                        idx_d      = '0;
                        in_ready_d = 1'b0;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            UPD: begin
                wr_en = 1'b1;
                if (idx_q == AW'(N - 2)) begin
                    state_d = PRED;
                    idx_d   = AW'(1);
                end else begin
                    idx_d = idx_q + AW'(2);
                end
            end
            PRED: begin
                wr_en = 1'b1;
                if (idx_q == AW'(N - 1)) begin
                    state_d = DRAIN;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + AW'(2);
                end
            end
            DRAIN: begin
                // idx points at the next sample to load into the output register.
                if (out_valid_q && bus.out_ready_i && out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = LOAD;
                    idx_d       = '0;
                end else if (!out_valid_q || bus.out_ready_i) begin
                    out_valid_d = 1'b1;
                    out_data_d  = row_buf[idx_q];
                    out_last_d  = (idx_q == AW'(N - 1));
                    idx_d       = idx_q + AW'(1);
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_data_o  = out_data_q;
    assign bus.out_last_o  = out_last_q;
    assign bus.busy_o      = (state_q != LOAD);

endmodule

// File: tb/tb_jp_inv_lift53.sv
// Scoreboard bench for jp_inv_lift53: an N=4 and an N=64 instance share clock
// and reset; directed rows push hand-computed results, monitors pop and compare.
module tb_jp_inv_lift53;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } exp_t;

    logic clk;
    logic rst_n;

    jp_inv_lift53_if #(.W(16)) bus4 ();
    jp_inv_lift53_if #(.W(16)) bus64 ();

    jp_inv_lift53 #(.W(16), .N(4), .AW(2)) u_dut4 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus4)
    );

    jp_inv_lift53 #(.W(16), .N(64), .AW(6)) u_dut64 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus64)
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp4[$];
    exp_t exp64[$];

    int   last_in_cyc4 = 0;
    int   row_seq4 = 0;
    int   seen_seq4 = 0;
    bit   prev_valid4 = 0;
    bit   stall_mode = 0;
    int   stall_ph = 0;
    bit [5:0] stall_pat = 6'b101001;

    int   in_cnt64 = 0;
    bit   rdy_low64 = 0;
    bit   rise_chk64 = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    task automatic report_fail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got timeout/unexpected event expected normal completion at cycle %0d", name, cyc);
    endtask

    task automatic push_exp4(input int a, input int b, input int c, input int d);
        exp_t e;
        e.data = 16'(a); e.last = 0; exp4.push_back(e);
        e.data = 16'(b); e.last = 0; exp4.push_back(e);
        e.data = 16'(c); e.last = 0; exp4.push_back(e);
        e.data = 16'(d); e.last = 1; exp4.push_back(e);
    endtask

    // Offers one row to the N=4 instance; with wiggle the source keeps valid high
    // and scrambles data whenever the block is not ready.
    task automatic apply_stimulus(input int a, input int b, input int c, input int d, input bit wiggle);
        logic [15:0] row [4];
        row[0] = 16'(a); row[1] = 16'(b); row[2] = 16'(c); row[3] = 16'(d);
        for (int k = 0; k < 4; k++) begin
            int  waited = 0;
            bit  done = 0;
            while (!done) begin
                if (bus4.in_ready_o) begin
                    bus4.in_valid_i = 1;
                    bus4.in_data_i  = row[k];
                    @(posedge clk); #1;
                    done = 1;
                end else begin
                    bus4.in_valid_i = wiggle;
                    bus4.in_data_i  = 16'($urandom);
                    @(posedge clk); #1;
                    waited++;
                    if (waited > 300) begin
                        report_fail("in_ready4_wait");
                        done = 1;
                    end
                end
            end
        end
        last_in_cyc4 = cyc;
        row_seq4++;
        bus4.in_valid_i = wiggle;
        bus4.in_data_i  = 16'($urandom);
    endtask

    task automatic send_row64();
        exp_t e;
        for (int k = 0; k < 64; k++) begin
            e.data = 16'd100;
            e.last = (k == 63);
            exp64.push_back(e);
        end
        for (int k = 0; k < 64; k++) begin
            int waited = 0;
            while (!bus64.in_ready_o && waited <= 300) begin
                bus64.in_valid_i = 0;
                @(posedge clk); #1;
                waited++;
            end
            if (waited > 300) report_fail("in_ready64_wait");
            bus64.in_valid_i = 1;
            bus64.in_data_i  = (k % 2 == 0) ? 16'd100 : 16'd0;
            @(posedge clk); #1;
        end
        bus64.in_valid_i = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(exp4.size() == 0 && exp64.size() == 0 && !bus4.out_valid_o && !bus64.out_valid_o
                 && !bus4.busy_o && !bus64.busy_o) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= budget) report_fail("drain_timeout");
    endtask

    always @(posedge clk) begin
        #1;
        if (stall_mode) begin
            bus4.out_ready_i = stall_pat[stall_ph % 6];
            stall_ph++;
        end else begin
            bus4.out_ready_i = 1;
        end
    end

    // N=4 monitor: ordered data/last against the queue head, also while stalled,
    // plus the last-beat-to-first-valid latency of every completed row.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid4 = 0;
        end else begin
            if (bus4.out_valid_o) begin
                if (!prev_valid4 && seen_seq4 != row_seq4) begin
                    check_output("latency4", 32'(cyc - last_in_cyc4), 32'd5);
                    seen_seq4 = row_seq4;
                end
                if (exp4.size() == 0) begin
                    report_fail("unexpected_out4");
                end else begin
                    check_output("data4", 32'(bus4.out_data_o), 32'(exp4[0].data));
                    check_output("last4", 32'(bus4.out_last_o), 32'(exp4[0].last));
                    if (bus4.out_ready_i) void'(exp4.pop_front());
                end
            end
            prev_valid4 = bus4.out_valid_o;
        end
    end

    // N=64 monitor: scoreboard plus in_ready staying low for the whole row.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_cnt64   = 0;
            rdy_low64  = 0;
            rise_chk64 = 0;
        end else begin
            if (rise_chk64) begin
                check_output("in_ready64_rise", 32'(bus64.in_ready_o), 32'd1);
                check_output("out_valid64_drop", 32'(bus64.out_valid_o), 32'd0);
                rise_chk64 = 0;
            end
            if (rdy_low64) begin
                check_output("in_ready64_low", 32'(bus64.in_ready_o), 32'd0);
                if (bus64.out_valid_o && bus64.out_ready_i && bus64.out_last_o) begin
                    rdy_low64  = 0;
                    rise_chk64 = 1;
                end
            end
            if (bus64.in_valid_i && bus64.in_ready_o) begin
                in_cnt64++;
                if (in_cnt64 == 64) begin
                    in_cnt64  = 0;
                    rdy_low64 = 1;
                end
            end
            if (bus64.out_valid_o) begin
                if (exp64.size() == 0) begin
                    report_fail("unexpected_out64");
                end else begin
                    check_output("data64", 32'(bus64.out_data_o), 32'(exp64[0].data));
                    check_output("last64", 32'(bus64.out_last_o), 32'(exp64[0].last));
                    if (bus64.out_ready_i) void'(exp64.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n = 0;
        bus4.in_valid_i   = 0;
        bus4.in_data_i    = 0;
        bus64.in_valid_i  = 0;
        bus64.in_data_i   = 0;
        bus4.out_ready_i  = 1;
        bus64.out_ready_i = 1;
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_in_ready4", 32'(bus4.in_ready_o), 32'd1);
        check_output("rst_out_valid4", 32'(bus4.out_valid_o), 32'd0);
        check_output("rst_busy4", 32'(bus4.busy_o), 32'd0);
        check_output("rst_in_ready64", 32'(bus64.in_ready_o), 32'd1);
        check_output("rst_out_data64", 32'(bus64.out_data_o), 32'd0);
        rst_n = 1;
        @(posedge clk); #1;

        $display("[TB] basic N=4 row");
        push_exp4(164, 160, 176, 180);
        apply_stimulus(159, -10, 175, 4, 0);
        wait_idle(200);

        $display("[TB] N=64 constant row");
        send_row64();
        wait_idle(400);

        $display("[TB] N=4 row with output stalls");
        stall_mode = 1;
        push_exp4(164, 160, 176, 180);
        apply_stimulus(159, -10, 175, 4, 0);
        wait_idle(200);
        stall_mode = 0;
        @(posedge clk); #1;

        $display("[TB] wrap row");
        push_exp4(16383, -16386, 16383, -16386);
        apply_stimulus(32767, 32767, 32767, 32767, 0);
        wait_idle(200);

        $display("[TB] reset during PRED");
        apply_stimulus(1, 2, 3, 4, 0);
        repeat (3) @(posedge clk);
        #1;
        check_output("busy_before_rst", 32'(bus4.busy_o), 32'd1);
        rst_n = 0;
        #1;
        check_output("midrst_out_valid4", 32'(bus4.out_valid_o), 32'd0);
        check_output("midrst_out_data4", 32'(bus4.out_data_o), 32'd0);
        check_output("midrst_out_last4", 32'(bus4.out_last_o), 32'd0);
        check_output("midrst_in_ready4", 32'(bus4.in_ready_o), 32'd1);
        check_output("midrst_busy4", 32'(bus4.busy_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        push_exp4(164, 160, 176, 180);
        apply_stimulus(159, -10, 175, 4, 0);
        wait_idle(200);

        $display("[TB] in_valid held high with changing data between rows");
        push_exp4(164, 160, 176, 180);
        push_exp4(16383, -16386, 16383, -16386);
        apply_stimulus(159, -10, 175, 4, 1);
        apply_stimulus(32767, 32767, 32767, 32767, 1);
        bus4.in_valid_i = 0;
        wait_idle(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no completion expected finish before 200000");
        $fatal(1, "[TB] global timeout");
    end

endmodule
